booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
Shares one sequential Booth_mult core (radix-4, start/done handshake) among NREQ butterfly/twiddle requesters in the NTT datapath. It arbitrates requests round-robin and drives the core's start and operand inputs. It captures the registered product and returns it with the requester ID over a valid/ready response channel. Only one operation is in flight at a time.

Parameters:
N, 18, operand width; product width is 2*N
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), requester ID width
TIMEOUT, (N>>1)+8, watchdog limit in BUSY cycles (used only with MULT_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_mplier  in  NREQ*N  flattened multipliers, slot i = [i*N +: N]
req_mcand  in  NREQ*N  flattened multiplicands
mul_start  out  1  start pulse to core
mul_mplier  out  N  operand to core
mul_mcand  out  N  operand to core
mul_done  in  1  core done strobe
mul_product  in  2*N  core product, valid the cycle after mul_done
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  requester index of the response
rsp_product  out  2*N  signed product
rsp_err  out  1  response is a timeout abort

Behaviour:
- Reset (async, n_reset=0): state=IDLE; rr_ptr=0; req_ready=0, mul_start=0, mul operands=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0. Reset mid-operation drops the in-flight op without a response. The core's reset is tied to the same n_reset at top level.
- FSM states: IDLE, BUSY, CAPTURE, RESP.
- IDLE: if any req_valid, pick grant g = first set bit searching from rr_ptr upward, wrapping at NREQ.
  - Combinationally assert req_ready[g]=1 and mul_start=1.
  - Drive mul_mplier/mul_mcand from slot g.
  - Register g. Set rr_ptr <= (g+1) mod NREQ. Go to BUSY.
  - If no req_valid: all outputs idle, rr_ptr unchanged.
- BUSY: mul_start=0 (mandatory; the core only completes with start low). Operands hold last values. On mul_done=1, go to CAPTURE.
- CAPTURE: one cycle. Register mul_product into rsp_product. Set rsp_id=g, rsp_err=0, rsp_valid<=1. Go to RESP.
- RESP: hold rsp_valid, rsp_id, rsp_product stable until rsp_valid&&rsp_ready. Then rsp_valid<=0, go to IDLE. A new grant is possible in the first IDLE cycle.
- Latency: mul_done in cycle T gives rsp_valid from cycle T+2. With the N=18 core, grant in cycle 0 gives mul_done in cycle 10 and rsp_valid in cycle 12.
- req_valid may drop without handshake. Requesters must hold operands only during their ready cycle.
- mul_done outside BUSY is ignored.
- req_ready is never asserted outside IDLE.

Optional Feature:
MULT_ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without mul_done, go directly to RESP with rsp_err=1, rsp_product=0, rsp_id=g.
  - A late mul_done is ignored.
  - mul_done in the same cycle as the limit counts as success.
- Undefined: no counter logic; rsp_err is constant 0. The port list is identical either way.

Decomposition:
- Package mult_arb_pkg: FSM state enum (IDLE, BUSY, CAPTURE, RESP), default N/NREQ constants, ID-width helper function.
- One sub-module, rr_arbiter: NREQ-wide request vector plus rr_ptr in; one-hot grant plus encoded index out; purely combinational. The FSM and pointer register stay in booth_mult_arbiter.

Test Plan:
- Single request: req 1, mplier=3, mcand=-5, rsp_ready=1 -> req_ready=0010 for one cycle, rsp_id=1, rsp_product=-15, rsp_valid in cycle 12.
- All four request continuously -> grants in order 0,1,2,3,0; products match operands; never two ready bits set.
- Back-pressure: rsp_ready=0 for 20 cycles -> rsp fields stable, no new req_ready, mul_start stays 0. Release -> IDLE next cycle.
- Corner operands: (-131072)*(-131072) = 2^34 and 131071*(-1) = -131071 -> exact 36-bit results.
- Reset asserted in cycle 5 of BUSY -> all outputs 0 immediately (async), no response. Next request served with rr_ptr=0.
- With MULT_ARB_TIMEOUT_EN and a core model that never asserts done -> rsp_err=1, rsp_product=0 after TIMEOUT=17 BUSY cycles. Without the macro -> arbiter waits indefinitely with rsp_err=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
// The optional watchdog is enabled by defining MULT_ARB_TIMEOUT_EN.
package mult_arb_pkg;

  localparam int N_DEF    = 18;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int pos;

  // Rotating priority search starting at ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[IDW'(pos)]) begin
        any = 1'b1;
        idx = IDW'(pos);
      end else begin
        any = any;
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin sharing of one sequential Booth multiplier among NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a BUSY watchdog that returns rsp_err=1.
module booth_mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int IDW     = id_width(NREQ),
  parameter int TIMEOUT = (N >> 1) + 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_mplier,
  input  logic [NREQ*N-1:0] req_mcand,
  output logic              mul_start,
  output logic [N-1:0]      mul_mplier,
  output logic [N-1:0]      mul_mcand,
  input  logic              mul_done,
  input  logic [2*N-1:0]    mul_product,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_product,
  output logic              rsp_err
);

  state_t           state_r, next_state_s;
  logic [IDW-1:0]   rr_ptr_r, gnt_id_r;
  logic [IDW-1:0]   arb_idx_s;
  logic [NREQ-1:0]  arb_grant_s;
  logic             arb_any_s;
  logic             grant_s;
  logic             timeout_hit_s;
  logic [N-1:0]     mplier_r, mcand_r;
  logic [N-1:0]     slot_mplier_s, slot_mcand_s;
  logic             rsp_valid_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [2*N-1:0]   rsp_product_r;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  assign slot_mplier_s = req_mplier[int'(arb_idx_s)*N +: N];
  assign slot_mcand_s  = req_mcand[int'(arb_idx_s)*N +: N];
  assign grant_s       = (state_r == IDLE) && arb_any_s;

  // Next-state logic; a done strobe wins over a coincident watchdog expiry.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (arb_any_s) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          next_state_s = CAPTURE;
        end else if (timeout_hit_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY;
        end
      end
      CAPTURE: next_state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Grant-cycle outputs: ready/start are same-cycle, operands hold afterwards.
  always_comb begin
    req_ready  = '0;
    mul_start  = 1'b0;
    mul_mplier = mplier_r;
    mul_mcand  = mcand_r;
    if (grant_s) begin
      req_ready  = arb_grant_s;
      mul_start  = 1'b1;
      mul_mplier = slot_mplier_s;
      mul_mcand  = slot_mcand_s;
    end else begin
      req_ready  = '0;
      mul_start  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant bookkeeping: winner id, rotated pointer and held operands.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rr_ptr_r <= '0;
      gnt_id_r <= '0;
      mplier_r <= '0;
      mcand_r  <= '0;
    end else if (grant_s) begin
      rr_ptr_r <= (arb_idx_s == IDW'(NREQ-1)) ? '0 : arb_idx_s + IDW'(1);
      gnt_id_r <= arb_idx_s;
      mplier_r <= slot_mplier_s;
      mcand_r  <= slot_mcand_s;
    end
  end

  // Response channel registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rsp_valid_r   <= 1'b0;
      rsp_id_r      <= '0;
      rsp_product_r <= '0;
    end else if (state_r == CAPTURE) begin
      rsp_valid_r   <= 1'b1;
      rsp_id_r      <= gnt_id_r;
      rsp_product_r <= mul_product;
    end else if ((state_r == BUSY) && !mul_done && timeout_hit_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_id_r      <= gnt_id_r;
      rsp_product_r <= '0;
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_valid_r   <= 1'b0;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] busy_cnt_r;
  logic            rsp_err_r;

  // Expiry fires on the TIMEOUT-th BUSY cycle.
  assign timeout_hit_s = (busy_cnt_r == CNTW'(TIMEOUT - 1));

  // BUSY cycle counter, cleared on every grant.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      busy_cnt_r <= '0;
    end else if (grant_s) begin
      busy_cnt_r <= '0;
    end else if (state_r == BUSY) begin
      busy_cnt_r <= busy_cnt_r + CNTW'(1);
    end
  end

  // Error flag accompanying a watchdog abort response.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rsp_err_r <= 1'b0;
    end else if (state_r == CAPTURE) begin
      rsp_err_r <= 1'b0;
    end else if ((state_r == BUSY) && !mul_done && timeout_hit_s) begin
      rsp_err_r <= 1'b1;
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_err_r <= 1'b0;
    end
  end

  assign rsp_err = rsp_err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  assign rsp_valid   = rsp_valid_r;
  assign rsp_id      = rsp_id_r;
  assign rsp_product = rsp_product_r;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized self-checking bench for booth_mult_arbiter with a behavioural
// 10-cycle multiplier core and a round-robin/product reference model.
module tb_booth_mult_arbiter;

  localparam int N    = 18;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              n_reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_mplier;
  logic [NREQ*N-1:0] req_mcand;
  logic              mul_start;
  logic [N-1:0]      mul_mplier;
  logic [N-1:0]      mul_mcand;
  logic              mul_done;
  logic [2*N-1:0]    mul_product;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_product;
  logic              rsp_err;

  int             n_tests = 0;
  int             n_fail  = 0;
  int             m_ptr   = 0;
  int             last_g  = 0;
  logic [2*N-1:0] last_p;
  logic [N-1:0]   op_a [NREQ];
  logic [N-1:0]   op_b [NREQ];

  logic           core_busy;
  logic           core_hang = 1'b0;
  int             core_cnt;
  logic [N-1:0]   ca, cb;

  booth_mult_arbiter dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mplier  (req_mplier),
    .req_mcand   (req_mcand),
    .mul_start   (mul_start),
    .mul_mplier  (mul_mplier),
    .mul_mcand   (mul_mcand),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  // Core model: done in the 10th cycle after start, product valid one cycle later.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      core_busy   <= 1'b0;
      core_cnt    <= 0;
      mul_done    <= 1'b0;
      mul_product <= '0;
      ca          <= '0;
      cb          <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start && !core_busy) begin
        core_busy <= 1'b1;
        core_cnt  <= 0;
        ca        <= mul_mplier;
        cb        <= mul_mcand;
      end else if (core_busy) begin
        if (mul_done) begin
          mul_product <= $signed(ca) * $signed(cb);
          core_busy   <= 1'b0;
        end else if (!core_hang && core_cnt == 8) begin
          mul_done <= 1'b1;
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] ref_mul(input logic [17:0] a, input logic [17:0] b);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (a[17]) x = x - 262144;
    if (b[17]) y = y - 262144;
    p = x * y;
    return p[35:0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_mplier[i*N +: N] = op_a[i];
      req_mcand[i*N +: N]  = op_b[i];
    end
  endtask

  task automatic scramble_bus();
    for (int i = 0; i < NREQ; i++) begin
      req_mplier[i*N +: N] = N'($urandom);
      req_mcand[i*N +: N]  = N'($urandom);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = N'($urandom);
      op_b[i] = N'($urandom);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_reset   = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    m_ptr   = 0;
  endtask

  // One request/response transaction; bp = cycles of response back-pressure.
  task automatic do_op(input logic [NREQ-1:0] vld, input int bp);
    int g, c;
    bit bad;
    logic [2*N-1:0] exp_p;
    @(negedge clk);
    check("rsp_cleared", 64'(rsp_valid), 64'd0);
    rsp_ready = (bp == 0);
    req_valid = vld;
    drive_ops();
    #1;
    g = pick(vld, m_ptr);
    check("req_ready", 64'(req_ready), 64'd1 << g);
    check("mul_start", 64'(mul_start), 64'd1);
    check("mul_mplier", 64'(mul_mplier), 64'(op_a[g]));
    check("mul_mcand", 64'(mul_mcand), 64'(op_b[g]));
    exp_p  = ref_mul(op_a[g], op_b[g]);
    m_ptr  = (g + 1) % NREQ;
    last_g = g;
    @(negedge clk);
    req_valid = '0;
    scramble_bus();
    c   = 1;
    bad = 1'b0;
    while (!rsp_valid && c < 40) begin
      if (req_ready != '0 || mul_start) bad = 1'b1;
      @(negedge clk);
      c++;
    end
    check("busy_quiet", 64'(bad), 64'd0);
    check("latency", 64'(c), 64'd12);
    check("rsp_id", 64'(rsp_id), 64'(g));
    check("rsp_product", 64'(rsp_product), 64'(exp_p));
    check("rsp_err", 64'(rsp_err), 64'd0);
    last_p = rsp_product;
    if (bp > 0) begin
      req_valid = '1;
      bad = 1'b0;
      repeat (bp) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_product !== exp_p || rsp_id !== IDW'(g) ||
            req_ready != '0 || mul_start) bad = 1'b1;
      end
      check("bp_stable", 64'(bad), 64'd0);
      req_valid = '0;
      rsp_ready = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    int g;
    bit bad;
    n_reset    = 1'b0;
    req_valid  = '0;
    req_mplier = '0;
    req_mcand  = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 64'({req_ready, mul_start, rsp_valid, rsp_id, rsp_err}), 64'd0);
    check("reset_ops", 64'({mul_mplier, mul_mcand}), 64'd0);
    check("reset_prod", 64'(rsp_product), 64'd0);
    @(negedge clk);
    n_reset = 1'b1;

    // Single request from slot 1: 3 * -5.
    rand_ops();
    op_a[1] = 18'd3;
    op_b[1] = 18'h3FFFB;
    do_op(4'b0010, 0);
    check("single_prod", 64'(last_p), 64'(36'hFFFFFFFF1));

    // All requesters continuously.
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      do_op(4'b1111, 0);
    end

    // Long back-pressure.
    rand_ops();
    do_op(4'($urandom_range(1, 15)), 20);

    // Corner operands.
    op_a[0] = 18'h20000;
    op_b[0] = 18'h20000;
    do_op(4'b0001, 0);
    check("corner_min_sq", 64'(last_p), 64'(36'h400000000));
    op_a[3] = 18'h1FFFF;
    op_b[3] = 18'h3FFFF;
    do_op(4'b1000, 0);
    check("corner_max_neg1", 64'(last_p), 64'(36'hFFFFE0001));

    // Random traffic.
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      do_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
    end

    // Reset in the 5th BUSY cycle.
    rand_ops();
    @(negedge clk);
    req_valid = 4'b0100;
    drive_ops();
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check("midrst_ctl", 64'({req_ready, mul_start, rsp_valid, rsp_id, rsp_err}), 64'd0);
    check("midrst_ops", 64'({mul_mplier, mul_mcand}), 64'd0);
    check("midrst_prod", 64'(rsp_product), 64'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    m_ptr   = 0;
    bad     = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) bad = 1'b1;
    end
    check("midrst_no_rsp", 64'(bad), 64'd0);
    rand_ops();
    do_op(4'b1010, 0);
    check("post_rst_grant", 64'(last_g), 64'd1);

    // Core that never completes.
    core_hang = 1'b1;
    rand_ops();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    drive_ops();
    #1;
    g = pick(4'b0001, m_ptr);
    check("hang_grant", 64'(req_ready), 64'd1 << g);
    @(negedge clk);
    req_valid = '0;
    c = 1;
    while (!rsp_valid && c < 60) begin
      @(negedge clk);
      c++;
    end
`ifdef MULT_ARB_TIMEOUT_EN
    check("tmo_latency", 64'(c), 64'd18);
    check("tmo_err", 64'(rsp_err), 64'd1);
    check("tmo_prod", 64'(rsp_product), 64'd0);
    check("tmo_id", 64'(rsp_id), 64'(g));
    rsp_ready = 1'b1;
    @(negedge clk);
    check("tmo_release", 64'(rsp_valid), 64'd0);
`else
    check("hang_wait", 64'(rsp_valid), 64'd0);
    check("hang_err", 64'(rsp_err), 64'd0);
`endif
    core_hang = 1'b0;
    apply_reset();
    rand_ops();
    do_op(4'b0001, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
